viterbi_decoder: RTL and testbench



---
 rtl/viterbi_decoder.sv | 129 ++++++++++++
 tb/tb_viterbi_decoder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_decoder.sv
// viterbi_decoder: hard-decision Viterbi decoder for the rate-1/2, K=3
// convolutional code (generators 111 / 101).
// A 4-state add-compare-select array with register-exchange survivors emits
// one decoded bit per accepted symbol after a TB_DEPTH-1 symbol fill period.
// Optional feature: define VITERBI_ERRCNT_EN to add the err_cnt output, which
// accumulates the per-symbol normalisation amount (corrected bit errors).
module viterbi_decoder #(
    parameter int unsigned TB_DEPTH = 15,
    parameter int unsigned PM_WIDTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  c,
    input  logic        in_valid,
    output logic        d,
    output logic        out_valid
`ifdef VITERBI_ERRCNT_EN
    ,
    output logic [15:0] err_cnt
`endif
);

    localparam int unsigned GW = PM_WIDTH + 1;
    localparam int unsigned FW = $clog2(TB_DEPTH);
    localparam logic [FW-1:0] FILL_MAX = FW'(TB_DEPTH - 1);

    logic [PM_WIDTH-1:0] pm_q   [4];
    logic [PM_WIDTH-1:0] pm_d   [4];
    logic [TB_DEPTH-1:0] surv_q [4];
    logic [TB_DEPTH-1:0] surv_d [4];
    logic [GW-1:0]       cand0  [4];
    logic [GW-1:0]       cand1  [4];
    logic [GW-1:0]       npm    [4];
    logic [3:0]          pick1;
    logic [GW-1:0]       min_pm;
    logic [1:0]          best;
    logic [FW-1:0]       fill_q;
    logic                d_q;
    logic                ov_q;

    // Hamming distance between the received symbol and the transition's
    // expected symbol {b^D_1, b^D_0^D_1}; pd0/pd1 are the predecessor's D_0/D_1.
    function automatic logic [1:0] branch_metric(input logic [1:0] sym,
                                                 input logic b,
                                                 input logic pd0,
                                                 input logic pd1);
        logic [1:0] diff;
        diff = sym ^ {b ^ pd1, b ^ pd0 ^ pd1};
        return {1'b0, diff[0]} + {1'b0, diff[1]};
    endfunction

    // ACS for every state, then normalisation and best-state selection.
    // State s = {D_0, D_1}; its predecessors are {D_1, 0} and {D_1, 1}.
    always_comb begin
        pick1 = '0;
        for (int unsigned s = 0; s < 4; s++) begin
            cand0[s] = {1'b0, pm_q[{s[0], 1'b0}]} + GW'(branch_metric(c, s[1], s[0], 1'b0));
            cand1[s] = {1'b0, pm_q[{s[0], 1'b1}]} + GW'(branch_metric(c, s[1], s[0], 1'b1));
            // strict compare: a tie keeps the predecessor with D_1 = 0
            pick1[s] = cand1[s] < cand0[s];
            npm[s]   = pick1[s] ? cand1[s] : cand0[s];
            surv_d[s] = pick1[s] ? {surv_q[{s[0], 1'b1}][TB_DEPTH-2:0], s[1]}
                                 : {surv_q[{s[0], 1'b0}][TB_DEPTH-2:0], s[1]};
        end
        min_pm = npm[0];
        best   = 2'd0;
        for (int unsigned s = 1; s < 4; s++) begin
            if (npm[s] < min_pm) begin
                min_pm = npm[s];
                best   = 2'(s);
            end
        end
        for (int unsigned s = 0; s < 4; s++) begin
            pm_d[s] = PM_WIDTH'(npm[s] - min_pm);
        end
    end

    // Metric, survivor, fill and output registers; updated only on accepted symbols.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned s = 0; s < 4; s++) begin
                pm_q[s]   <= (s == 0) ? '0 : PM_WIDTH'(8);
                surv_q[s] <= '0;
            end
            fill_q <= '0;
            d_q    <= 1'b0;
            ov_q   <= 1'b0;
        end else begin
            ov_q <= 1'b0;
            if (in_valid) begin
                pm_q   <= pm_d;
                surv_q <= surv_d;
                if (fill_q != FILL_MAX) begin
                    fill_q <= fill_q + 1'b1;
                end else begin
                    ov_q <= 1'b1;
                    d_q  <= surv_d[best][TB_DEPTH-1];
                end
            end
        end
    end

    assign d         = d_q;
    assign out_valid = ov_q;

`ifdef VITERBI_ERRCNT_EN
    logic [15:0] err_q;
    logic [15:0] err_d;
    logic [16:0] err_sum;

    // Saturating accumulation of the normalisation amount.
    always_comb begin
        err_sum = {1'b0, err_q} + 17'(min_pm);
        err_d   = err_sum[16] ? '1 : err_sum[15:0];
    end

    // Error counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= '0;
        end else if (in_valid) begin
            err_q <= err_d;
        end
    end

    assign err_cnt = err_q;
`endif

endmodule

// File: tb/tb_viterbi_decoder.sv
// tb_viterbi_decoder: scoreboard bench for viterbi_decoder.
// Stimulus encodes known data with a behavioural K=3 encoder, optionally
// flips sparse single bits; the expected decoded bit (the original data bit
// TB_DEPTH-1 symbols earlier) is queued, and a monitor pops on out_valid.
module tb_viterbi_decoder;

    localparam int TBD = 15;

    logic       clk;
    logic       reset;
    logic [1:0] c;
    logic       in_valid;
    logic       d;
    logic       out_valid;
`ifdef VITERBI_ERRCNT_EN
    logic [15:0] err_cnt;
`endif

    viterbi_decoder #(
        .TB_DEPTH (TBD),
        .PM_WIDTH (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .c         (c),
        .in_valid  (in_valid),
        .d         (d),
        .out_valid (out_valid)
`ifdef VITERBI_ERRCNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit chk;
        bit val;
    } exp_t;

    exp_t sb[$];
    bit   hist[$];
    int   checks    = 0;
    int   failures  = 0;
    int   sym_idx   = 0;
    int   err_exp   = 0;
    int   rst_count = 0;
    bit   e0 = 1'b0;
    bit   e1 = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one accepted symbol, queueing its expected output if one is due.
    task automatic push_and_drive(input logic [1:0] sym, input bit known, input bit expv, input int gap);
        if (sym_idx >= TBD - 1) sb.push_back('{known, expv});
        sym_idx++;
        c        = sym;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        c        = 2'($urandom);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Encode data bit b from the reference encoder state, apply error mask.
    task automatic enc_send(input bit b, input logic [1:0] emask, input int gap);
        logic [1:0] sym;
        bit         expv;
        sym = {b ^ e1, b ^ e0 ^ e1} ^ emask;
        e1  = e0;
        e0  = b;
        hist.push_back(b);
        err_exp += $countones(emask);
        expv = (sym_idx >= TBD - 1) ? hist[sym_idx - (TBD - 1)] : 1'b0;
        push_and_drive(sym, 1'b1, expv, gap);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        reset = 1'b0;
        rst_count++;
        #1;
        chk("rst_d", 32'(d), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
`ifdef VITERBI_ERRCNT_EN
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
        chk("sb_empty_at_reset", 32'(sb.size()), 32'd0);
        sb.delete();
        hist.delete();
        sym_idx = 0;
        err_exp = 0;
        e0      = 1'b0;
        e1      = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic drain(input string name);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk(name, 32'(sb.size()), 32'd0);
`ifdef VITERBI_ERRCNT_EN
        chk({name, "_err_cnt"}, 32'(err_cnt), 32'(err_exp));
`endif
    endtask

    // Monitor: accepted-edge tracking, output popping and hold checks.
    logic acc_prev = 1'b0;
    logic d_prev;
    int   seen_rst = 0;

    always @(posedge clk) acc_prev <= in_valid && reset;

    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1) begin
            checks++;
            if (!acc_prev) begin
                failures++;
                $display("FAIL out_valid_cadence: got 1 expected 0 (no accepting edge) at %0t", $time);
            end
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output: got out_valid=1 d=%b expected no output at %0t", d, $time);
            end else begin
                e = sb.pop_front();
                if (e.chk) begin
                    if (d !== e.val) begin
                        failures++;
                        $display("FAIL decoded_bit: got %b expected %b at %0t", d, e.val, $time);
                    end
                end else if ($isunknown(d)) begin
                    failures++;
                    $display("FAIL d_known: got %b expected 0/1 at %0t", d, $time);
                end
            end
        end else if (out_valid !== 1'b0 && reset === 1'b1 && rst_count > 0) begin
            checks++;
            failures++;
            $display("FAIL out_valid_known: got %b expected 0/1 at %0t", out_valid, $time);
        end
        if (!acc_prev && reset === 1'b1 && seen_rst == rst_count && rst_count > 0) begin
            checks++;
            if (d !== d_prev) begin
                failures++;
                $display("FAIL d_hold: got %b expected %b at %0t", d, d_prev, $time);
            end
        end
        d_prev   = d;
        seen_rst = rst_count;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    bit pat[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        int n;
        int next_err;
        int gap;
        logic [1:0] em;
        reset    = 1'b1;
        in_valid = 1'b0;
        c        = 2'b00;
        repeat (2) @(posedge clk);
        #1;

        // all-zero stream: 6 outputs of 0
        do_reset();
        repeat (20) enc_send(1'b0, 2'b00, 0);
        drain("t1_zero");

        // known pattern, clean channel
        do_reset();
        for (int i = 0; i < 20; i++) enc_send(i < 6 ? pat[i] : 1'b0, 2'b00, 0);
        drain("t2_pattern");

        // single bit error on symbol 2 (00 -> 01)
        do_reset();
        for (int i = 0; i < 20; i++) enc_send(i < 6 ? pat[i] : 1'b0, (i == 2) ? 2'b01 : 2'b00, 0);
        drain("t3_one_error");

        // gaps of 3 idle cycles between symbols
        do_reset();
        for (int i = 0; i < 20; i++) enc_send(i < 6 ? pat[i] : 1'b0, 2'b00, 3);
        drain("t4_gaps");

        // reset mid-stream after 10 symbols, then a fresh stream
        do_reset();
        repeat (10) enc_send(1'($urandom), 2'b00, 0);
        do_reset();
        repeat (40) enc_send(1'($urandom), 2'b00, 0);
        drain("t5_midreset");

        // constant 11 symbols: outputs unpredictable but must be known
        do_reset();
        repeat (20) push_and_drive(2'b11, 1'b0, 1'b0, 0);
        drain("t6_all11");

        // random data, sparse single-bit errors, random gaps
        for (int t = 0; t < 6; t++) begin
            do_reset();
            n        = 60 + int'($urandom_range(0, 40));
            next_err = 8 + int'($urandom_range(0, 7));
            for (int i = 0; i < n; i++) begin
                em = 2'b00;
                if (i == next_err && i < n - 20) begin
                    em       = $urandom_range(0, 1) ? 2'b10 : 2'b01;
                    next_err = next_err + 20 + int'($urandom_range(0, 9));
                end
                gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : 0;
                enc_send(1'($urandom), em, gap);
            end
            drain("t7_random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
